// File: rtl/mau_pkg.sv
// Shared encodings and lane helpers for the memory access unit.
// Lanes are big-endian: byte offset 0 is bits 31:24, halfword offset 0 is bits 31:16.
package mau_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RSP  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    localparam logic [31:0] LANE_MASK_BYTE = 32'h0000_00FF;
    localparam logic [31:0] LANE_MASK_HALF = 32'h0000_FFFF;
    localparam logic [31:0] LANE_MASK_WORD = 32'hFFFF_FFFF;

    function automatic size_e op_size(input op_e op);
        case (op)
            OP_LB, OP_LBU, OP_SB: op_size = SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: op_size = SZ_HALF;
            default:              op_size = SZ_WORD;
        endcase
    endfunction

    function automatic logic op_signed(input op_e op);
        op_signed = (op == OP_LB) || (op == OP_LH);
    endfunction

    function automatic logic op_is_store(input op_e op);
        op_is_store = (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

    // Right-shift that brings the addressed lane down to bit 0.
    function automatic logic [4:0] lane_shift(input logic [1:0] off, input size_e sz);
        case (sz)
            SZ_BYTE: lane_shift = {~off, 3'b000};
            SZ_HALF: lane_shift = {~off[1], 4'b0000};
            default: lane_shift = 5'd0;
        endcase
    endfunction

    // Drops the low offset bits that a naturally aligned access of this size ignores.
    function automatic logic [1:0] align_off(input logic [1:0] off, input size_e sz);
        case (sz)
            SZ_BYTE: align_off = off;
            SZ_HALF: align_off = {off[1], 1'b0};
            default: align_off = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mau_lane.sv
// Combinational lane extract/extend for loads and lane merge for byte/halfword stores.
module mau_lane
    import mau_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [4:0]  shift;
    logic [31:0] mask;
    logic [31:0] lane;

    always_comb begin
        shift = lane_shift(offset_i, size_e'(size_i));
        case (size_e'(size_i))
            SZ_BYTE: mask = LANE_MASK_BYTE;
            SZ_HALF: mask = LANE_MASK_HALF;
            default: mask = LANE_MASK_WORD;
        endcase
        lane = (word_i >> shift) & mask;

        case (size_e'(size_i))
            SZ_BYTE: load_o = signed_i ? {{24{lane[7]}}, lane[7:0]} : {24'd0, lane[7:0]};
            SZ_HALF: load_o = signed_i ? {{16{lane[15]}}, lane[15:0]} : {16'd0, lane[15:0]};
            default: load_o = lane;
        endcase

        merge_o = (word_i & ~(mask << shift)) | ((wdata_i & mask) << shift);
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for the MEM stage; byte/halfword stores run as read-modify-write.
// Optional macro MAU_MISALIGN_TRAP_EN turns misaligned accesses into error responses.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int DM_WORDS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        dm_r,
    output logic        dm_w,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata
);

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic [29:0] idx_q, idx_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] wdata_q, wdata_d;
    logic        dm_r_q, dm_r_d;
    logic        dm_w_q, dm_w_d;
    logic [31:0] dm_addr_q, dm_addr_d;
    logic [31:0] dm_wdata_q, dm_wdata_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    op_e         req_op_e;
    size_e       req_size;
    logic        range_err;
    logic        misalign;
    logic        req_err;
    logic [31:0] lane_load;
    logic [31:0] lane_merge;
    logic [1:0]  lane_size;
    logic        lane_signed;

    assign req_op_e  = op_e'(req_op);
    assign req_size  = op_size(req_op_e);
    assign range_err = {2'b00, req_addr[31:2]} >= 32'(DM_WORDS);

`ifdef MAU_MISALIGN_TRAP_EN
    assign misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                      ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign req_err     = range_err || misalign;
    assign lane_size   = op_size(op_q);
    assign lane_signed = op_signed(op_q);

    // Operates on the live read word so the RD cycle's data lands directly in the output registers.
    mau_lane u_lane (
        .word_i   (dm_rdata),
        .offset_i (off_q),
        .size_i   (lane_size),
        .signed_i (lane_signed),
        .wdata_i  (wdata_q),
        .load_o   (lane_load),
        .merge_o  (lane_merge)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        idx_d       = idx_q;
        off_d       = off_q;
        wdata_d     = wdata_q;
        dm_r_d      = 1'b0;
        dm_w_d      = 1'b0;
        dm_addr_d   = 32'd0;
        dm_wdata_d  = 32'd0;
        rsp_rdata_d = 32'd0;
        rsp_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op_e;
                    idx_d   = req_addr[31:2];
                    off_d   = align_off(req_addr[1:0], req_size);
                    wdata_d = req_wdata;
                    if (req_err) begin
                        state_d   = ST_RSP;
                        rsp_err_d = 1'b1;
                    end else if (req_op_e == OP_SW) begin
                        state_d    = ST_WR;
                        dm_w_d     = 1'b1;
                        dm_addr_d  = {2'b00, req_addr[31:2]};
                        dm_wdata_d = req_wdata;
                    end else begin
                        state_d   = ST_RD;
                        dm_r_d    = 1'b1;
                        dm_addr_d = {2'b00, req_addr[31:2]};
                    end
                end
            end
            ST_RD: begin
                if (op_is_store(op_q)) begin
                    state_d    = ST_WR;
                    dm_w_d     = 1'b1;
                    dm_addr_d  = {2'b00, idx_q};
                    dm_wdata_d = lane_merge;
                end else begin
                    state_d     = ST_RSP;
                    rsp_rdata_d = lane_load;
                end
            end
            ST_WR:   state_d = ST_RSP;
            ST_RSP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_LW;
            idx_q       <= 30'd0;
            off_q       <= 2'd0;
            wdata_q     <= 32'd0;
            dm_r_q      <= 1'b0;
            dm_w_q      <= 1'b0;
            dm_addr_q   <= 32'd0;
            dm_wdata_q  <= 32'd0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            idx_q       <= idx_d;
            off_q       <= off_d;
            wdata_q     <= wdata_d;
            dm_r_q      <= dm_r_d;
            dm_w_q      <= dm_w_d;
            dm_addr_q   <= dm_addr_d;
            dm_wdata_q  <= dm_wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RSP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign dm_r      = dm_r_q;
    assign dm_w      = dm_w_q;
    assign dm_addr   = dm_addr_q;
    assign dm_wdata  = dm_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small word memory model attached to the dm port.
module tb_mem_access_unit;

    localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3, LBU = 3'd4,
                           SW = 3'd5, SH = 3'd6, SB = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        dm_r;
    logic        dm_w;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;

    int n_vec = 0;
    int n_err = 0;
    int overlap = 0;

    logic [31:0] mem [8];
    logic        bd_we = 1'b0;
    logic [2:0]  bd_idx = 3'd0;
    logic [31:0] bd_data = 32'd0;

    always #5 clk = ~clk;

    assign dm_rdata = (dm_addr < 32'd8) ? mem[dm_addr[2:0]] : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        if (bd_we)
            mem[bd_idx] <= bd_data;
        else if (dm_w && dm_addr < 32'd8)
            mem[dm_addr[2:0]] <= dm_wdata;
    end

    mem_access_unit #(.DM_WORDS(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .dm_r      (dm_r),
        .dm_w      (dm_w),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata)
    );

    task automatic poke(input logic [2:0] idx, input logic [31:0] val);
        @(negedge clk);
        bd_we = 1'b1; bd_idx = idx; bd_data = val;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    // Issues one request, then watches 8 cycles after the accept edge (cycle 1 = first cycle after it).
    task automatic run_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          output int rsp_cyc, output logic [31:0] rdata, output logic err,
                          output int nr, output int nw, output logic [31:0] waddr,
                          output logic [31:0] wseen, output logic rdy_rsp, output logic rdy_after);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        rsp_cyc = -1; rdata = 32'd0; err = 1'b0; nr = 0; nw = 0;
        waddr = 32'd0; wseen = 32'd0; rdy_rsp = 1'b1; rdy_after = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (dm_r) nr++;
            if (dm_w) begin
                nw++;
                waddr = dm_addr;
                wseen = dm_wdata;
            end
            if (dm_r && dm_w) overlap++;
            if (rsp_valid && rsp_cyc < 0) begin
                rsp_cyc = c;
                rdata = rsp_rdata;
                err = rsp_err;
                rdy_rsp = req_ready;
            end else if (rsp_cyc == c - 1) begin
                rdy_after = req_ready;
            end
            @(posedge clk); #1;
        end
        $display("op=%0d addr=%h wdata=%h -> rsp_cyc=%0d rdata=%h err=%0b dm_r=%0d dm_w=%0d",
                 op, addr, wd, rsp_cyc, rdata, err, nr, nw);
    endtask

    int          cyc, nr, nw;
    logic [31:0] rd, wa, wdv;
    logic        er, rr, ra;

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({rsp_valid, rsp_err, dm_r, dm_w, req_ready} !== 5'b00001 ||
            dm_addr !== 32'd0 || dm_wdata !== 32'd0 || rsp_rdata !== 32'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%0b e=%0b r=%0b w=%0b rdy=%0b addr=%h wd=%h rd=%h, want all 0 with rdy=1",
                     rsp_valid, rsp_err, dm_r, dm_w, req_ready, dm_addr, dm_wdata, rsp_rdata);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: got %0b want 1", req_ready);
        end
    endtask

    task automatic test_sw_lw();
        run_op(SW, 32'h8, 32'hDEADBEEF, cyc, rd, er, nr, nw, wa, wdv, rr, ra);
        n_vec++;
        if (cyc !== 2 || nw !== 1 || nr !== 0 || wa !== 32'd2 || wdv !== 32'hDEADBEEF || er !== 1'b0 || rd !== 32'd0) begin
            n_err++;
            $display("FAIL sw: cyc=%0d nw=%0d nr=%0d addr=%h data=%h err=%0b rd=%h want 2 1 0 2 deadbeef 0 0",
                     cyc, nw, nr, wa, wdv, er, rd);
        end
        run_op(LW, 32'h8, 32'h0, cyc, rd, er, nr, nw, wa, wdv, rr, ra);
        n_vec++;
        if (cyc !== 2 || rd !== 32'hDEADBEEF || nr !== 1 || nw !== 0 || er !== 1'b0) begin
            n_err++;
            $display("FAIL lw: cyc=%0d rd=%h nr=%0d nw=%0d err=%0b want 2 deadbeef 1 0 0", cyc, rd, nr, nw, er);
        end
    endtask

    task automatic test_sub_word_store();
        poke(3'd2, 32'h11223344);
        run_op(SB, 32'h9, 32'h123456AA, cyc, rd, er, nr, nw, wa, wdv, rr, ra);
        n_vec++;
        if (cyc !== 3 || nr !== 1 || nw !== 1 || wa !== 32'd2 || wdv !== 32'h11AA3344 || er !== 1'b0) begin
            n_err++;
            $display("FAIL sb: cyc=%0d nr=%0d nw=%0d addr=%h data=%h err=%0b want 3 1 1 2 11aa3344 0",
                     cyc, nr, nw, wa, wdv, er);
        end
        run_op(SH, 32'hA, 32'h9999BEEF, cyc, rd, er, nr, nw, wa, wdv, rr, ra);
        n_vec++;
        if (cyc !== 3 || wdv !== 32'h11AABEEF || mem[2] !== 32'h11AABEEF) begin
            n_err++;
            $display("FAIL sh: cyc=%0d data=%h mem=%h want 3 11aabeef 11aabeef", cyc, wdv, mem[2]);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  ops [6];
        logic [31:0] adr [6];
        logic [31:0] exp [6];
        ops = '{LB, LBU, LH, LHU, LB, LH};
        adr = '{32'h8, 32'h9, 32'hA, 32'h8, 32'hB, 32'h8};
        exp = '{32'hFFFFFF80, 32'h000000FF, 32'h00007F01, 32'h000080FF, 32'h00000001, 32'hFFFF80FF};
        poke(3'd2, 32'h80FF7F01);
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], adr[i], 32'h0, cyc, rd, er, nr, nw, wa, wdv, rr, ra);
            n_vec++;
            if (cyc !== 2 || rd !== exp[i] || er !== 1'b0 || nw !== 0) begin
                n_err++;
                $display("FAIL load%0d: cyc=%0d rd=%h err=%0b nw=%0d want 2 %h 0 0", i, cyc, rd, er, nw, exp[i]);
            end
        end
    endtask

    task automatic test_range();
        poke(3'd7, 32'h0BADCAFE);
        run_op(LW, 32'h1C, 32'h0, cyc, rd, er, nr, nw, wa, wdv, rr, ra);
        n_vec++;
        if (cyc !== 2 || rd !== 32'h0BADCAFE || er !== 1'b0) begin
            n_err++;
            $display("FAIL lw_last: cyc=%0d rd=%h err=%0b want 2 0badcafe 0", cyc, rd, er);
        end
        run_op(LW, 32'h20, 32'h0, cyc, rd, er, nr, nw, wa, wdv, rr, ra);
        n_vec++;
        if (cyc !== 1 || er !== 1'b1 || rd !== 32'd0 || nr !== 0 || nw !== 0) begin
            n_err++;
            $display("FAIL lw_range: cyc=%0d err=%0b rd=%h nr=%0d nw=%0d want 1 1 0 0 0", cyc, er, rd, nr, nw);
        end
        run_op(SB, 32'h21, 32'hFF, cyc, rd, er, nr, nw, wa, wdv, rr, ra);
        n_vec++;
        if (cyc !== 1 || er !== 1'b1 || nr !== 0 || nw !== 0) begin
            n_err++;
            $display("FAIL sb_range: cyc=%0d err=%0b nr=%0d nw=%0d want 1 1 0 0", cyc, er, nr, nw);
        end
    endtask

    task automatic test_misalign();
        poke(3'd1, 32'hCAFE1234);
        run_op(LH, 32'h5, 32'h0, cyc, rd, er, nr, nw, wa, wdv, rr, ra);
        n_vec++;
`ifdef MAU_MISALIGN_TRAP_EN
        if (cyc !== 1 || er !== 1'b1 || rd !== 32'd0 || nr !== 0 || nw !== 0) begin
            n_err++;
            $display("FAIL lh_misalign: cyc=%0d err=%0b rd=%h nr=%0d nw=%0d want 1 1 0 0 0", cyc, er, rd, nr, nw);
        end
`else
        if (cyc !== 2 || er !== 1'b0 || rd !== 32'hFFFFCAFE || nr !== 1) begin
            n_err++;
            $display("FAIL lh_misalign: cyc=%0d err=%0b rd=%h nr=%0d want 2 0 ffffcafe 1", cyc, er, rd, nr);
        end
`endif
    endtask

    task automatic test_back_to_back();
        run_op(LW, 32'h4, 32'h0, cyc, rd, er, nr, nw, wa, wdv, rr, ra);
        n_vec++;
        if (rr !== 1'b0 || ra !== 1'b1 || rd !== 32'hCAFE1234) begin
            n_err++;
            $display("FAIL ready_timing: rdy_in_rsp=%0b rdy_after=%0b rd=%h want 0 1 cafe1234", rr, ra, rd);
        end
        n_vec++;
        if (overlap !== 0) begin
            n_err++;
            $display("FAIL rw_overlap: got %0d cycles with dm_r and dm_w both high, want 0", overlap);
        end
    endtask

    task automatic test_reset_mid();
        int w_seen;
        int guard;
        poke(3'd2, 32'h11223344);
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1; req_op = SB; req_addr = 32'h9; req_wdata = 32'hAA;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_vec++;
        if (dm_r !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_rd: dm_r=%0b want 1", dm_r);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if ({rsp_valid, rsp_err, dm_r, dm_w, req_ready} !== 5'b00001 ||
            dm_addr !== 32'd0 || dm_wdata !== 32'd0 || rsp_rdata !== 32'd0) begin
            n_err++;
            $display("FAIL rst_mid_outputs: v=%0b e=%0b r=%0b w=%0b rdy=%0b addr=%h wd=%h rd=%h want 0 0 0 0 1 0 0 0",
                     rsp_valid, rsp_err, dm_r, dm_w, req_ready, dm_addr, dm_wdata, rsp_rdata);
        end
        rst_n = 1'b1;
        w_seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (dm_w) w_seen++;
        end
        n_vec++;
        if (w_seen !== 0 || mem[2] !== 32'h11223344 || req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_nowrite: dm_w cycles=%0d mem=%h rdy=%0b want 0 11223344 1", w_seen, mem[2], req_ready);
        end
        $display("reset during SB RD: dm_w cycles after reset=%0d mem[2]=%h", w_seen, mem[2]);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 32'd0;
        test_reset();
        test_sw_lw();
        test_sub_word_store();
        test_loads();
        test_range();
        test_misalign();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
